// File: rtl/micro_prod_accum.sv
// -----------------------------------------------------------------------------
// micro_prod_accum
//
// Downstream stage of the micro-tile nibble multiplier. Sums N_SAMPLES unsigned
// 8-bit products into a saturating ACC_W-bit accumulator. Each frame total is
// then returned as two bytes, low byte first, over a valid/ready handshake.
//
// Handshake (acc_byte/byte_valid/rd_ready):
//   A byte transfers on a rising clk edge where byte_valid=1 and rd_ready=1.
//   Once byte_valid is high, acc_byte and byte_valid hold steady until that
//   transfer happens; they are never retracted. The only exceptions are clear
//   and rst_n, which abort the dump. The upstream product stream has no ready
//   signal. Products offered while busy=1 are dropped.
//
// Parameters:
//   N_SAMPLES  products summed per frame (1..255)
//   ACC_W      accumulator width in bits (9..16)
//
// Ports:
//   clk         clock, all state on rising edge
//   rst_n       asynchronous active-low reset
//   prod_in     product from upstream multiplier, unsigned
//   prod_valid  prod_in valid this cycle
//   clear       synchronous abort/flush, highest priority after reset
//   rd_ready    downstream ready to take acc_byte
//   acc_byte    current result byte (0x00 when nothing is presented)
//   byte_valid  acc_byte valid
//   busy        a frame result is being drained; samples are not accepted
//   overflow    sticky saturation flag for the current frame
//
// The FSM state register is the signal 'state' (type state_t). It can be
// observed hierarchically.
// -----------------------------------------------------------------------------
module micro_prod_accum #(
  parameter int N_SAMPLES = 4,
  parameter int ACC_W     = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] prod_in,
  input  logic       prod_valid,
  input  logic       clear,
  input  logic       rd_ready,
  output logic [7:0] acc_byte,
  output logic       byte_valid,
  output logic       busy,
  output logic       overflow
);

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    DUMP_LO = 2'd1,
    DUMP_HI = 2'd2
  } state_t;

  // count value held while the final sample of a frame is being accepted
  localparam logic [7:0] LAST_IDX = 8'(N_SAMPLES - 1);

  state_t           state, state_nx;
  logic [ACC_W-1:0] acc, acc_nx;
  logic [7:0]       count, count_nx;
  logic             ovf, ovf_nx;

  // One extra bit of headroom. sum[ACC_W] set means the add overflowed.
  logic [ACC_W:0]   sum;
  logic [15:0]      acc_ext;

  assign sum     = {1'b0, acc} + {{(ACC_W-7){1'b0}}, prod_in};
  // Zero-extend to 16 bits so the high byte is acc[ACC_W-1:8] padded with 0.
  assign acc_ext = 16'(acc);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      count <= count_nx;
      ovf   <= ovf_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    count_nx = count;
    ovf_nx   = ovf;

    case (state)
      ACCUM: begin
        if (prod_valid) begin
          acc_nx   = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
          ovf_nx   = ovf | sum[ACC_W];
          count_nx = count + 8'd1;
          if (count == LAST_IDX) begin
            state_nx = DUMP_LO;
          end
        end
      end

      DUMP_LO: begin
        if (rd_ready) begin
          state_nx = DUMP_HI;
        end
      end

      DUMP_HI: begin
        // The high byte leaves, so the frame is done and the next one starts clean.
        if (rd_ready) begin
          state_nx = ACCUM;
          acc_nx   = '0;
          count_nx = '0;
          ovf_nx   = 1'b0;
        end
      end

      default: begin
        state_nx = ACCUM;
        acc_nx   = '0;
        count_nx = '0;
        ovf_nx   = 1'b0;
      end
    endcase

    // Flush overrides everything. A sample offered in this cycle is discarded.
    if (clear) begin
      state_nx = ACCUM;
      acc_nx   = '0;
      count_nx = '0;
      ovf_nx   = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from registered state only
  // ---------------------------------------------------------------------------
  always_comb begin
    acc_byte   = 8'h00;
    byte_valid = 1'b0;
    busy       = 1'b0;
    case (state)
      DUMP_LO: begin
        acc_byte   = acc_ext[7:0];
        byte_valid = 1'b1;
        busy       = 1'b1;
      end
      DUMP_HI: begin
        acc_byte   = acc_ext[15:8];
        byte_valid = 1'b1;
        busy       = 1'b1;
      end
      default: begin
        acc_byte   = 8'h00;
        byte_valid = 1'b0;
        busy       = 1'b0;
      end
    endcase
  end

  assign overflow = ovf;

endmodule

// File: tb/tb_micro_prod_accum.sv
// -----------------------------------------------------------------------------
// tb_micro_prod_accum
//
// Directed testbench for micro_prod_accum.
//   u_dut : default parameters (N_SAMPLES=4, ACC_W=12)
//   u_sat : N_SAMPLES=17, ACC_W=12, used for the saturation frame
// Inputs change 1 time unit after the rising edge. Outputs are sampled on the
// falling edge. Bytes that u_dut hands over are checked against exp_q.
// -----------------------------------------------------------------------------
module tb_micro_prod_accum;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // u_dut signals
  logic [7:0] prod_in    = 8'h00;
  logic       prod_valid = 1'b0;
  logic       clear      = 1'b0;
  logic       rd_ready   = 1'b1;
  logic [7:0] acc_byte;
  logic       byte_valid;
  logic       busy;
  logic       overflow;

  // u_sat signals
  logic [7:0] s_prod_in    = 8'h00;
  logic       s_prod_valid = 1'b0;
  logic       s_clear      = 1'b0;
  logic       s_rd_ready   = 1'b1;
  logic [7:0] s_acc_byte;
  logic       s_byte_valid;
  logic       s_busy;
  logic       s_overflow;

  micro_prod_accum u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prod_in    (prod_in),
    .prod_valid (prod_valid),
    .clear      (clear),
    .rd_ready   (rd_ready),
    .acc_byte   (acc_byte),
    .byte_valid (byte_valid),
    .busy       (busy),
    .overflow   (overflow)
  );

  micro_prod_accum #(.N_SAMPLES(17), .ACC_W(12)) u_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .prod_in    (s_prod_in),
    .prod_valid (s_prod_valid),
    .clear      (s_clear),
    .rd_ready   (s_rd_ready),
    .acc_byte   (s_acc_byte),
    .byte_valid (s_byte_valid),
    .busy       (s_busy),
    .overflow   (s_overflow)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // A byte transfers at the next rising edge whenever valid and ready are both high here.
  always @(negedge clk) begin
    if (rst_n && !clear && byte_valid && rd_ready) begin
      if (exp_q.size() == 0) check("extra_byte", 32'(acc_byte) + 32'h100, 32'h0);
      else check("byte", 32'(acc_byte), 32'(exp_q.pop_front()));
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic send(input logic [7:0] p);
    prod_in    = p;
    prod_valid = 1'b1;
    @(posedge clk); #1;
    prod_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] p, input logic [7:0] lo, input logic [7:0] hi);
    exp_q.push_back(lo);
    exp_q.push_back(hi);
    repeat (4) send(p);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int nbusy;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_acc_byte", 32'(acc_byte), 32'h00);
    check("rst_byte_valid", 32'(byte_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Test 1: 0x0F+0x10+0x20+0x01 = 0x040
    exp_q.push_back(8'h40);
    exp_q.push_back(8'h00);
    send(8'h0F); send(8'h10); send(8'h20); send(8'h01);
    nbusy = 0;
    @(negedge clk);
    check("t1_first_byte_latency", 32'(byte_valid), 32'h1);
    check("t1_overflow", 32'(overflow), 32'h0);
    if (busy) nbusy++;
    repeat (5) begin @(negedge clk); if (busy) nbusy++; end
    check("t1_busy_cycles", 32'(nbusy), 32'd2);
    check("t1_q_drained", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;

    // Test 2: 17 x 0xFF = 4335 saturates to 0xFFF
    for (int i = 0; i < 17; i++) begin
      s_prod_in    = 8'hFF;
      s_prod_valid = 1'b1;
      @(posedge clk); #1;
    end
    s_prod_valid = 1'b0;
    @(negedge clk);
    check("t2_lo_valid", 32'(s_byte_valid), 32'h1);
    check("t2_lo_byte", 32'(s_acc_byte), 32'hFF);
    check("t2_lo_overflow", 32'(s_overflow), 32'h1);
    @(negedge clk);
    check("t2_hi_byte", 32'(s_acc_byte), 32'h0F);
    check("t2_hi_overflow", 32'(s_overflow), 32'h1);
    @(negedge clk);
    check("t2_after_valid", 32'(s_byte_valid), 32'h0);
    check("t2_after_overflow", 32'(s_overflow), 32'h0);
    @(posedge clk); #1;

    // Test 3: 0xFF+0xA6+0+0 = 0x1A5, held in DUMP_LO for 5 cycles
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h01);
    rd_ready = 1'b0;
    send(8'hFF); send(8'hA6); send(8'h00); send(8'h00);
    for (int i = 0; i < 5; i++) begin
      prod_in    = 8'h01;
      prod_valid = (i % 2 == 0);
      @(negedge clk);
      check("t3_hold_byte", 32'(acc_byte), 32'hA5);
      check("t3_hold_valid", 32'(byte_valid), 32'h1);
      @(posedge clk); #1;
    end
    prod_valid = 1'b0;
    rd_ready   = 1'b1;
    idle(2);
    check("t3_back_to_accum", 32'(u_dut.state), 32'd0);
    send_frame(8'h01, 8'h04, 8'h00);
    check("t3_q_drained", 32'(exp_q.size()), 32'd0);

    // Test 4: clear in DUMP_HI after LO transferred (4 x 0x05 = 0x14)
    exp_q.push_back(8'h14);
    repeat (4) send(8'h05);
    @(posedge clk); #1;             // LO transferred, now in DUMP_HI
    check("t4_in_dump_hi", 32'(u_dut.state), 32'd2);
    rd_ready = 1'b0;
    clear    = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    check("t4_clear_valid", 32'(byte_valid), 32'h0);
    check("t4_clear_state", 32'(u_dut.state), 32'd0);
    check("t4_clear_count", 32'(u_dut.count), 32'd0);
    @(posedge clk); #1;
    rd_ready = 1'b1;
    send_frame(8'h02, 8'h08, 8'h00);
    check("t4_q_drained", 32'(exp_q.size()), 32'd0);

    // Test 5: reset mid-frame after 2 samples
    send(8'h09); send(8'h09);
    rst_n = 1'b0;
    #2;
    check("t5_rst_count", 32'(u_dut.count), 32'd0);
    check("t5_rst_acc", 32'(u_dut.acc), 32'd0);
    check("t5_rst_byte", 32'(acc_byte), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(8'h03, 8'h0C, 8'h00);
    check("t5_q_drained", 32'(exp_q.size()), 32'd0);

    // Test 5b: reset mid-dump drops the pending byte asynchronously
    rd_ready = 1'b0;
    repeat (4) send(8'h10);
    rst_n = 1'b0;
    #1;
    check("t5b_rst_valid", 32'(byte_valid), 32'h0);
    check("t5b_rst_busy", 32'(busy), 32'h0);
    check("t5b_rst_byte", 32'(acc_byte), 32'h00);
    @(negedge clk);
    rst_n    = 1'b1;
    rd_ready = 1'b1;
    @(posedge clk); #1;

    // Test 6: clear together with a sample at count=3
    repeat (3) send(8'h01);
    check("t6_count3", 32'(u_dut.count), 32'd3);
    prod_in    = 8'h50;
    prod_valid = 1'b1;
    clear      = 1'b1;
    @(posedge clk); #1;
    prod_valid = 1'b0;
    clear      = 1'b0;
    @(negedge clk);
    check("t6_no_dump", 32'(byte_valid), 32'h0);
    check("t6_count0", 32'(u_dut.count), 32'd0);
    check("t6_acc0", 32'(u_dut.acc), 32'd0);
    @(posedge clk); #1;
    send_frame(8'h04, 8'h10, 8'h00);

    idle(3);
    check("final_q_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Safety net: the directed sequence is short, so this only fires if the bench stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/micro_prod_accum.md
Name: micro_prod_accum

Overview:
- Downstream stage of the micro-tile nibble multiplier; consumes its 8-bit product stream.
- Sums a fixed number of products into a saturating accumulator.
- Returns each frame total as two bytes (low byte first) over a valid/ready handshake.
- Sits between the multiplier tile output and the byte-wide readout path.

Parameters:
N_SAMPLES, 4, products summed per frame; legal 1..255
ACC_W, 12, accumulator width in bits; legal 9..16

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
prod_in  input  8  product from upstream multiplier, unsigned
prod_valid  input  1  prod_in valid this cycle
clear  input  1  synchronous abort/flush, highest priority after reset
rd_ready  input  1  downstream ready to take acc_byte
acc_byte  output  8  current result byte
byte_valid  output  1  acc_byte valid
busy  output  1  high while a frame result is being drained (samples not accepted)
overflow  output  1  sticky saturation flag for the current frame

Behaviour:
- Reset (rst_n low, async): state=ACCUM, acc=0, count=0, overflow=0; outputs acc_byte=0x00, byte_valid=0, busy=0. All outputs registered or decoded from registered state only.
- States: ACCUM, DUMP_LO, DUMP_HI.
- ACCUM: a sample is accepted when prod_valid=1. acc <= sat(acc + prod_in); count <= count+1.
  - When the accepted sample is number N_SAMPLES, the next state is DUMP_LO. acc then includes that sample.
  - byte_valid=0 and busy=0 in ACCUM.
- Saturation:
  - The sum is computed at ACC_W+1 bits.
  - If it is >= 2^ACC_W, acc <= 2^ACC_W-1 and overflow <= 1.
  - overflow is sticky until the frame is drained or cleared.
- DUMP_LO: byte_valid=1, busy=1, acc_byte=acc[7:0]. On rd_ready=1, go to DUMP_HI.
- DUMP_HI: byte_valid=1, busy=1, acc_byte = acc[ACC_W-1:8] zero-extended to 8 bits.
  - On rd_ready=1: go to ACCUM; acc<=0, count<=0, overflow<=0.
- acc_byte and byte_valid hold stable while byte_valid=1 and rd_ready=0 (no retraction).
- prod_valid is ignored in DUMP_LO and DUMP_HI. Those samples are dropped: not counted, not buffered. Upstream must gate on busy.
- First-sample latency: a frame's first byte is valid on the cycle after the Nth sample is accepted. With rd_ready held high, the next frame's first sample can be accepted 3 cycles after the Nth sample of the previous frame.
- clear=1 (synchronous, any state): next state ACCUM; acc=0, count=0, overflow=0; any accepted prod_valid that cycle is discarded. clear aborts a dump mid-way; the high byte is never presented.
- Reset mid-frame or mid-dump: immediate return to reset values; no partial byte completes.
- N_SAMPLES=1: every accepted sample produces a frame.
- prod_in=0 samples still count toward N_SAMPLES.

Test Plan:
- Reset then 4 samples 0x0F,0x10,0x20,0x01 with rd_ready=1 (defaults) -> bytes 0x40 then 0x00, overflow=0, busy high exactly 2 cycles.
- 17 samples of 0xFF with N_SAMPLES=17, ACC_W=12 -> saturates at 0xFFF; bytes 0xFF then 0x0F; overflow=1 during dump, 0 after HI transfer.
- Frame result of 0x1A5 with rd_ready held low 5 cycles in DUMP_LO -> acc_byte=0xA5 and byte_valid stable throughout; prod_valid pulses during the dump are not counted. The next frame of 4×0x01 returns 0x04, 0x00.
- clear asserted in DUMP_HI (after LO accepted) -> byte_valid=0 next cycle, state ACCUM, count=0. The next 4×0x02 frame yields 0x08, 0x00.
- rst_n pulsed low mid-frame after 2 samples -> outputs return to 0 asynchronously. After release, 4×0x03 yields 0x0C, 0x00 (pre-reset samples lost).
- Simultaneous clear and prod_valid (prod_in=0x50) with count=3 -> sample discarded, no dump, count=0.
